// File: rtl/ffe_tap_sequencer_if.sv
// Purpose: bundle of sample, coefficient-write, MAC-control and result-handshake signals for the FFE tap sequencer.
// Latency: none; this is wiring only.
// Backpressure: in_ready/in_valid on the input side, out_valid/out_ready on the result side.
interface ffe_tap_sequencer_if #(
    parameter int NUM_TAPS = 3,
    parameter int TAP_W    = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1
);
    logic             in_valid;
    logic             in_ready;
    logic             coef_wr_req;
    logic             coef_wr_gnt;
    logic             shift_en;
    logic             acc_clr;
    logic             acc_en;
    logic [TAP_W-1:0] tap_sel;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    // Sequencer side
    modport master (
        input  in_valid, coef_wr_req, out_ready,
        output in_ready, coef_wr_gnt, shift_en, acc_clr, acc_en, tap_sel, out_valid, busy
    );

    // Environment side: sample source, coefficient writer, datapath and sink
    modport slave (
        output in_valid, coef_wr_req, out_ready,
        input  in_ready, coef_wr_gnt, shift_en, acc_clr, acc_en, tap_sel, out_valid, busy
    );
endinterface

// File: rtl/ffe_tap_sequencer.sv
// Purpose: sequences one shared MAC across NUM_TAPS taps per sample and arbitrates coefficient writes.
// Latency: accept at k -> shift/clear at k+1, MAC k+2..k+NUM_TAPS+1, out_valid at k+NUM_TAPS+2.
// Backpressure: out_valid holds (accumulator frozen) until out_ready; in_ready only in IDLE without a write request.
module ffe_tap_sequencer #(
    parameter int NUM_TAPS = 3,
    parameter int TAP_W    = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ffe_tap_sequencer_if.master   sif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COEF  = 3'd1,
        SHIFT = 3'd2,
        MAC   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

    state_t           state, state_nxt;
    logic [TAP_W-1:0] tap_cnt, tap_cnt_nxt;

    // State and tap counter registers; reset drops any partial sum in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tap_cnt <= tap_cnt_nxt;
        end
    end

    // Next-state, counter and Moore output decode; in_ready also looks at the write request
    always_comb begin
        state_nxt       = state;
        tap_cnt_nxt     = tap_cnt;
        sif.in_ready    = 1'b0;
        sif.coef_wr_gnt = 1'b0;
        sif.shift_en    = 1'b0;
        sif.acc_clr     = 1'b0;
        sif.acc_en      = 1'b0;
        sif.tap_sel     = '0;
        sif.out_valid   = 1'b0;
        sif.busy        = 1'b1;

        case (state)
            IDLE: begin
                sif.busy     = 1'b0;
                // A pending coefficient write wins over a sample on the same cycle
                sif.in_ready = !sif.coef_wr_req && !rst;
                if (sif.coef_wr_req) begin
                    state_nxt = COEF;
                end else if (sif.in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            COEF: begin
                sif.coef_wr_gnt = 1'b1;
                state_nxt       = IDLE;
            end
            SHIFT: begin
                sif.shift_en = 1'b1;
                sif.acc_clr  = 1'b1;
                tap_cnt_nxt  = '0;
                state_nxt    = MAC;
            end
            MAC: begin
                sif.acc_en  = 1'b1;
                sif.tap_sel = tap_cnt;
                if (tap_cnt == LAST_TAP) begin
                    tap_cnt_nxt = '0;
                    state_nxt   = DONE;
                end else begin
                    tap_cnt_nxt = tap_cnt + TAP_W'(1);
                end
            end
            DONE: begin
                // Accumulator is frozen here so the sum stays stable while the sink stalls
                sif.out_valid = 1'b1;
                if (sif.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                tap_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ffe_tap_sequencer.sv
module tb_ffe_tap_sequencer;
    localparam int N  = 3;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst;

    ffe_tap_sequencer_if #(.NUM_TAPS(N), .TAP_W(TW)) bus ();

    ffe_tap_sequencer #(.NUM_TAPS(N), .TAP_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: age = cycles since the sample was accepted (0 = no sample in flight)
    int age      = 0;
    bit coef_cyc = 0;

    logic [31:0] o_ir, o_gnt, o_sh, o_clr, o_ae, o_ts, o_ov, o_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic capture();
        o_ir   = 32'(bus.in_ready);
        o_gnt  = 32'(bus.coef_wr_gnt);
        o_sh   = 32'(bus.shift_en);
        o_clr  = 32'(bus.acc_clr);
        o_ae   = 32'(bus.acc_en);
        o_ts   = 32'(bus.tap_sel);
        o_ov   = 32'(bus.out_valid);
        o_busy = 32'(bus.busy);
    endtask

    task automatic check_model(input bit r);
        logic [31:0] e_ir, e_gnt, e_sh, e_clr, e_ae, e_ts, e_ov, e_busy;
        e_ir = 0; e_gnt = 0; e_sh = 0; e_clr = 0; e_ae = 0; e_ts = 0; e_ov = 0; e_busy = 0;
        if (!r) begin
            if (coef_cyc) begin
                e_gnt = 1; e_busy = 1;
            end else if (age == 0) begin
                e_ir = 32'(!bus.coef_wr_req);
            end else if (age == 1) begin
                e_sh = 1; e_clr = 1; e_busy = 1;
            end else if (age <= N + 1) begin
                e_ae = 1; e_ts = 32'(age - 2); e_busy = 1;
            end else begin
                e_ov = 1; e_busy = 1;
            end
        end
        chk("in_ready",    o_ir,   e_ir);
        chk("coef_wr_gnt", o_gnt,  e_gnt);
        chk("shift_en",    o_sh,   e_sh);
        chk("acc_clr",     o_clr,  e_clr);
        chk("acc_en",      o_ae,   e_ae);
        chk("tap_sel",     o_ts,   e_ts);
        chk("out_valid",   o_ov,   e_ov);
        chk("busy",        o_busy, e_busy);
    endtask

    task automatic model_edge(input bit r, input bit iv, input bit req, input bit ordy);
        if (r) begin
            age = 0; coef_cyc = 0;
        end else if (coef_cyc) begin
            coef_cyc = 0;
        end else if (age == 0) begin
            if (req) coef_cyc = 1;
            else if (iv) age = 1;
        end else if (age <= N + 1) begin
            age++;
        end else if (ordy) begin
            age = 0;
        end
    endtask

    // One clock: drive at negedge, check 1 ns later, advance model at the following posedge
    task automatic step(input bit r, input bit iv, input bit req, input bit ordy);
        @(negedge clk);
        rst             = r;
        bus.in_valid    = iv;
        bus.coef_wr_req = req;
        bus.out_ready   = ordy;
        #1;
        capture();
        check_model(r);
        @(posedge clk);
        model_edge(r, iv, req, ordy);
        cyc++;
    endtask

    initial begin
        int sh_cyc[$];
        int n_ae, n_ov;
        bit rq, rr, riv, rord;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.coef_wr_req = 1'b0; bus.out_ready = 1'b0;

        // Reset and first idle cycle
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("rst_in_ready", o_ir, 0);
            chk("rst_busy", o_busy, 0);
        end
        step(0, 0, 0, 1);
        chk("post_rst_in_ready", o_ir, 1);
        chk("post_rst_busy", o_busy, 0);

        // Single sample with hand-derived cycle positions
        for (int c = 0; c <= 6; c++) begin
            step(0, c == 0, 0, 1);
            chk("ss_shift",     o_sh, 32'(c == 1));
            chk("ss_clr",       o_clr, 32'(c == 1));
            chk("ss_acc_en",    o_ae, 32'(c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) chk("ss_tap_sel", o_ts, 32'(c - 2));
            chk("ss_out_valid", o_ov, 32'(c == 5));
            chk("ss_in_ready",  o_ir, 32'(c == 0 || c == 6));
        end

        // Output stall for 4 cycles in DONE
        step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk("stall_out_valid", o_ov, 1);
            chk("stall_acc_en", o_ae, 0);
            chk("stall_in_ready", o_ir, 0);
        end
        step(0, 0, 0, 1);
        chk("stall_release_ov", o_ov, 1);
        step(0, 0, 0, 0);
        chk("stall_after_ov", o_ov, 0);
        chk("stall_after_ir", o_ir, 1);

        // Coefficient write and sample on the same IDLE cycle
        step(0, 1, 1, 1);
        chk("cw_idle_ir", o_ir, 0);
        chk("cw_idle_gnt", o_gnt, 0);
        step(0, 1, 1, 1);
        chk("cw_gnt", o_gnt, 1);
        chk("cw_gnt_ir", o_ir, 0);
        step(0, 1, 0, 1);
        chk("cw_accept_ir", o_ir, 1);
        step(0, 0, 0, 1);
        chk("cw_shift", o_sh, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1);
            chk("cw_mac_no_gnt", o_gnt, 0);
        end
        step(0, 0, 1, 1);
        chk("cw_late_idle_gnt", o_gnt, 0);
        chk("cw_late_idle_busy", o_busy, 0);
        step(0, 0, 1, 1);
        chk("cw_late_gnt", o_gnt, 1);
        step(0, 0, 0, 1);

        // Continuous streaming of 3 samples
        n_ae = 0; n_ov = 0;
        for (int c = 0; c < 18; c++) begin
            step(0, 1, 0, 1);
            if (o_sh == 1) sh_cyc.push_back(c);
            if (o_ae == 1) n_ae++;
            if (o_ov == 1) n_ov++;
        end
        chk("stream_shifts", 32'(sh_cyc.size()), 3);
        for (int i = 1; i < sh_cyc.size(); i++)
            chk("stream_gap", 32'(sh_cyc[i] - sh_cyc[i-1]), 6);
        chk("stream_acc_en", 32'(n_ae), 9);
        chk("stream_out_valid", 32'(n_ov), 3);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Async reset while MAC is on tap 1, applied between clock edges
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        #2;
        capture();
        chk("pre_rst_tap_sel", o_ts, 1);
        rst = 1'b1;
        #1;
        capture();
        chk("arst_acc_en", o_ae, 0);
        chk("arst_tap_sel", o_ts, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_in_ready", o_ir, 0);
        model_edge(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("arst_no_spurious_ov", o_ov, 0);
        for (int c = 0; c < 6; c++) begin
            step(0, c == 0, 0, 1);
            if (c == 2) chk("arst_restart_tap0", o_ts, 0);
            chk("arst_restart_ov", o_ov, 32'(c == 5));
        end

        // Randomized traffic against the model
        rq = 0;
        for (int i = 0; i < 3000; i++) begin
            rr   = ($urandom_range(0, 299) == 0);
            riv  = ($urandom_range(0, 1) == 1);
            rord = ($urandom_range(0, 9) < 7);
            if (!rq && $urandom_range(0, 11) == 0) rq = 1;
            if (rr) rq = 0;
            step(rr, riv, rq, rord);
            if (o_gnt == 1) rq = 0;
        end
        step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
